// File: rtl/edge_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// edge_conditioner_pkg : shared channel state encoding and counter sizing
// Rev 1.0
// ============================================================================
package edge_conditioner_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        PEND_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        PEND_LOW    = 2'd3
    } chan_state_t;

    // Width needed to hold 0..max_count, never narrower than one bit.
    function automatic int cnt_width(input int max_count);
        int w;
        w = $clog2(max_count + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_conditioner_channel.sv
`default_nettype none
// ============================================================================
// edge_conditioner_channel : synchroniser, debounce FSM and edge pulses for one input
// Rev 1.0
// ============================================================================
module edge_conditioner_channel
    import edge_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CW              = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_in,
    output logic o_level,
    output logic o_pos_edge,
    output logic o_neg_edge,
    output logic o_pos_next,
    output logic o_neg_next
);

    localparam logic [CW-1:0] c_cnt_last = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    chan_state_t            r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   r_pos;
    logic                   r_neg;
    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;

    assign w_s = r_sync[SYNC_STAGES-1];

    // With a one-cycle filter the change commits straight from the stable state.
    assign w_rise = w_s &&
                    (((r_state == PEND_HIGH) && (r_cnt == c_cnt_last)) ||
                     ((r_state == STABLE_LOW) && (DEBOUNCE_CYCLES == 1)));
    assign w_fall = !w_s &&
                    (((r_state == PEND_LOW) && (r_cnt == c_cnt_last)) ||
                     ((r_state == STABLE_HIGH) && (DEBOUNCE_CYCLES == 1)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync  <= '0;
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pos   <= 1'b0;
            r_neg   <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
            r_pos  <= w_rise;
            r_neg  <= w_fall;
            if (w_rise) begin
                r_state <= STABLE_HIGH;
                r_level <= 1'b1;
                r_cnt   <= '0;
            end else if (w_fall) begin
                r_state <= STABLE_LOW;
                r_level <= 1'b0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    STABLE_LOW: begin
                        if (w_s) begin
                            r_state <= PEND_HIGH;
                            r_cnt   <= c_cnt_one;
                        end else begin
                            r_cnt   <= '0;
                        end
                    end
                    PEND_HIGH: begin
                        if (!w_s) begin
                            r_state <= STABLE_LOW;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt   <= r_cnt + c_cnt_one;
                        end
                    end
                    STABLE_HIGH: begin
                        if (!w_s) begin
                            r_state <= PEND_LOW;
                            r_cnt   <= c_cnt_one;
                        end else begin
                            r_cnt   <= '0;
                        end
                    end
                    PEND_LOW: begin
                        if (w_s) begin
                            r_state <= STABLE_HIGH;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt   <= r_cnt + c_cnt_one;
                        end
                    end
                    default: begin
                        r_state <= STABLE_LOW;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_level    = r_level;
    assign o_pos_edge = r_pos;
    assign o_neg_edge = r_neg;
    assign o_pos_next = w_rise;
    assign o_neg_next = w_fall;

endmodule
`default_nettype wire

// File: rtl/edge_conditioner.sv
`default_nettype none
// ============================================================================
// edge_conditioner : N debounced channels with rise/fall pulses and any_edge.
// EDGE_CONDITIONER_STICKY_EN adds clear/sticky rise-capture flags.   Rev 1.0
// ============================================================================
module edge_conditioner
    import edge_conditioner_pkg::*;
#(
    parameter int N               = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    output logic [N-1:0] level,
    output logic [N-1:0] pos_edge,
    output logic [N-1:0] neg_edge,
    output logic         any_edge
`ifdef EDGE_CONDITIONER_STICKY_EN
    ,
    input  logic [N-1:0] clear,
    output logic [N-1:0] sticky
`endif
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic [N-1:0] w_pos_next;
    logic [N-1:0] w_neg_next;
    logic         r_any;

    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        edge_conditioner_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CW              (CW)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .i_in       (in[gi]),
            .o_level    (level[gi]),
            .o_pos_edge (pos_edge[gi]),
            .o_neg_edge (neg_edge[gi]),
            .o_pos_next (w_pos_next[gi]),
            .o_neg_next (w_neg_next[gi])
        );
    end

    // Built from next-state pulse terms so it lands on the same edge as the pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |{w_pos_next, w_neg_next};
        end
    end

    assign any_edge = r_any;

`ifdef EDGE_CONDITIONER_STICKY_EN
    logic [N-1:0] r_sticky;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= (r_sticky & ~clear) | pos_edge;
        end
    end

    assign sticky = r_sticky;
`endif

endmodule
`default_nettype wire

// File: tb/tb_edge_conditioner.sv
`default_nettype none
// ============================================================================
// tb_edge_conditioner : scoreboard bench for edge_conditioner (N=4, 2 sync, 4 debounce)
// Rev 1.0
// ============================================================================
module tb_edge_conditioner;

    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    // Edges after the edge that first captures a new input value.
    localparam int LAT  = SYNC + DEB - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] in_r = '0;
    logic [N-1:0] level, pos_edge, neg_edge;
    logic         any_edge;
    logic [N-1:0] clear_r = '0;
`ifdef EDGE_CONDITIONER_STICKY_EN
    logic [N-1:0] sticky;
`endif

    always #5 clk = ~clk;

    edge_conditioner #(
        .N               (N),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in_r),
        .level    (level),
        .pos_edge (pos_edge),
        .neg_edge (neg_edge),
        .any_edge (any_edge)
`ifdef EDGE_CONDITIONER_STICKY_EN
        ,
        .clear    (clear_r),
        .sticky   (sticky)
`endif
    );

    typedef struct {
        logic [N-1:0] level;
        logic [N-1:0] pos;
        logic [N-1:0] neg;
        logic         any;
        logic [N-1:0] sticky;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: input delay line plus a run-length count of disagreeing samples.
    logic [N-1:0] m_dl [SYNC];
    int           m_run [N];
    logic [N-1:0] m_level  = '0;
    logic [N-1:0] m_pos    = '0;
    logic [N-1:0] m_neg    = '0;
    logic [N-1:0] m_sticky = '0;

    int pc [N];
    int nc [N];
    int any_cnt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic clr_counts();
        for (int i = 0; i < N; i++) begin
            pc[i] = 0;
            nc[i] = 0;
        end
        any_cnt = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] vin, input logic vrst, input logic [N-1:0] vclr);
        logic [N-1:0] s, p, n, st;
        exp_t e;
        if (!vrst) begin
            for (int k = 0; k < SYNC; k++) m_dl[k] = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
            m_level  = '0;
            m_pos    = '0;
            m_neg    = '0;
            m_sticky = '0;
        end else begin
            s = m_dl[SYNC-1];
            for (int k = SYNC - 1; k > 0; k--) m_dl[k] = m_dl[k-1];
            m_dl[0] = vin;
            st = m_pos | (m_sticky & ~vclr);
            p = '0;
            n = '0;
            for (int i = 0; i < N; i++) begin
                if (s[i] != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_level[i] = s[i];
                        if (s[i]) p[i] = 1'b1;
                        else      n[i] = 1'b1;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_pos    = p;
            m_neg    = n;
            m_sticky = st;
        end
        e.level  = m_level;
        e.pos    = m_pos;
        e.neg    = m_neg;
        e.any    = |{m_pos, m_neg};
        e.sticky = m_sticky;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of stimulus, advance one edge, compare against the scoreboard.
    task automatic step(input logic [N-1:0] vin, input logic vrst, input logic [N-1:0] vclr);
        exp_t e;
        in_r    = vin;
        rst     = vrst;
        clear_r = vclr;
        model_edge(vin, vrst, vclr);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("level", 32'(level), 32'(e.level));
            check("pos_edge", 32'(pos_edge), 32'(e.pos));
            check("neg_edge", 32'(neg_edge), 32'(e.neg));
            check("any_edge", 32'(any_edge), 32'(e.any));
`ifdef EDGE_CONDITIONER_STICKY_EN
            check("sticky", 32'(sticky), 32'(e.sticky));
`endif
        end
        for (int i = 0; i < N; i++) begin
            pc[i] += int'(pos_edge[i]);
            nc[i] += int'(neg_edge[i]);
        end
        any_cnt += int'(any_edge);
    endtask

    task automatic hold(input logic [N-1:0] vin, input int cycles);
        for (int k = 0; k < cycles; k++) step(vin, 1'b1, '0);
    endtask

    initial begin
        logic [N-1:0] v;
        for (int k = 0; k < SYNC; k++) m_dl[k] = '0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
        clr_counts();
        #1;

        // 1: inputs high through reset, then release.
        for (int k = 0; k < 3; k++) begin
            step(4'hF, 1'b0, '0);
            check("t1_rst_level", 32'(level), 32'h0);
            check("t1_rst_pulse", 32'({pos_edge, neg_edge, any_edge}), 32'h0);
        end
        clr_counts();
        for (int k = 0; k <= LAT + 1; k++) begin
            step(4'hF, 1'b1, '0);
            if (k == LAT - 1) check("t1_level_early", 32'(level), 32'h0);
            if (k == LAT) begin
                check("t1_level", 32'(level), 32'hF);
                check("t1_pos", 32'(pos_edge), 32'hF);
                check("t1_any", 32'(any_edge), 32'h1);
            end
        end
        check("t1_any_count", 32'(any_cnt), 32'd1);
        hold(4'h0, 12);

        // 2: bouncing input never accumulates enough agreeing samples.
        clr_counts();
        for (int r = 0; r < 4; r++) begin
            hold(4'h1, 3);
            hold(4'h0, 3);
        end
        check("t2_level0", 32'(level[0]), 32'h0);
        check("t2_pulses", 32'(pc[0] + pc[1] + pc[2] + pc[3] + nc[0] + nc[1] + nc[2] + nc[3]), 32'd0);
        hold(4'h0, 6);

        // 3: clean rise then fall on channel 1.
        clr_counts();
        for (int k = 0; k < 10; k++) begin
            step(4'h2, 1'b1, '0);
            if (k == LAT) check("t3_pos_at_lat", 32'(pos_edge), 32'h2);
        end
        check("t3_level_hi", 32'(level[1]), 32'h1);
        for (int k = 0; k < 10; k++) begin
            step(4'h0, 1'b1, '0);
            if (k == LAT) check("t3_neg_at_lat", 32'(neg_edge), 32'h2);
        end
        check("t3_pos_count", 32'(pc[1]), 32'd1);
        check("t3_neg_count", 32'(nc[1]), 32'd1);
        check("t3_level_lo", 32'(level[1]), 32'h0);

        // 4: simultaneous rise on ch0 and fall on ch2.
        hold(4'h4, 10);
        clr_counts();
        for (int k = 0; k < 10; k++) begin
            step(4'h1, 1'b1, '0);
            if (k == LAT) begin
                check("t4_pos", 32'(pos_edge), 32'h1);
                check("t4_neg", 32'(neg_edge), 32'h4);
            end
        end
        check("t4_any_count", 32'(any_cnt), 32'd1);
        hold(4'h0, 10);

        // 5: reset in the middle of a pending rise on ch3.
        clr_counts();
        hold(4'h8, 4);
        step(4'h8, 1'b0, '0);
        step(4'h8, 1'b0, '0);
        check("t5_no_early_pulse", 32'(pc[3]), 32'd0);
        for (int k = 0; k <= LAT + 2; k++) begin
            step(4'h8, 1'b1, '0);
            if (k == LAT) check("t5_fresh_pos", 32'(pos_edge), 32'h8);
        end
        check("t5_pos_count", 32'(pc[3]), 32'd1);
        hold(4'h0, 10);

`ifdef EDGE_CONDITIONER_STICKY_EN
        // 6: sticky set, hold, clear alone, and set beating clear.
        hold(4'h1, 10);
        check("t6_sticky_set", 32'(sticky[0]), 32'h1);
        step(4'h1, 1'b1, 4'h1);
        check("t6_sticky_clr", 32'(sticky[0]), 32'h0);
        hold(4'h0, 10);
        for (int k = 0; k <= LAT + 3; k++) begin
            step(4'h1, 1'b1, (k == LAT + 1) ? 4'h1 : 4'h0);
            if (k == LAT + 1) check("t6_set_wins", 32'(sticky[0]), 32'h1);
        end
        hold(4'h0, 10);
`endif

        // Slow random toggling across all channels.
        v = '0;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(7) == 0) v[i] = ~v[i];
            step(v, ($urandom_range(149) != 0), 4'($urandom_range(15)) & 4'($urandom_range(15)));
            check("excl", 32'(pos_edge & neg_edge), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
